// File: rtl/uart_cmd_pkg.sv
// Shared character constants, FSM encoding and small helpers for the cat-control command decoder.
package uart_cmd_pkg;

  localparam logic [7:0] CH_UPPER_A    = 8'h41;
  localparam logic [7:0] CH_UPPER_F    = 8'h46;
  localparam logic [7:0] CH_UPPER_H    = 8'h48;
  localparam logic [7:0] CH_LOWER_A    = 8'h61;
  localparam logic [7:0] CH_LOWER_F    = 8'h66;
  localparam logic [7:0] CH_LOWER_H    = 8'h68;
  localparam logic [7:0] CH_DIGIT_0    = 8'h30;
  localparam logic [7:0] CH_DIGIT_9    = 8'h39;
  localparam logic [7:0] CH_CLEAR_ALL  = 8'h60;
  localparam logic [7:0] CH_HEX_PREFIX = 8'h23;
  localparam logic [7:0] CH_CR         = 8'h0D;
  localparam logic [7:0] CH_LF         = 8'h0A;
  localparam logic [7:0] CH_SPACE      = 8'h20;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HEX_HI = 2'd1,
    ST_HEX_LO = 2'd2,
    ST_APPLY  = 2'd3
  } state_e;

  // Error counter sticks at all-ones so a flood of garbage never wraps back to a clean-looking value
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == 8'hFF) begin
      return 8'hFF;
    end else begin
      return v + 8'd1;
    end
  endfunction

endpackage

// File: rtl/hex_nibble_decode.sv
// Combinational ASCII hex-digit classifier: byte -> {is_hex, nibble}.
module hex_nibble_decode
  import uart_cmd_pkg::*;
(
  input  logic [7:0] byte_i,
  output logic       is_hex_o,
  output logic [3:0] nibble_o
);

  // Letters a-f/A-F share the same low nibble offset (1..6), so +9 maps them to 10..15
  always_comb begin
    is_hex_o = 1'b0;
    nibble_o = 4'h0;
    if ((byte_i >= CH_DIGIT_0) && (byte_i <= CH_DIGIT_9)) begin
      is_hex_o = 1'b1;
      nibble_o = byte_i[3:0];
    end else if (((byte_i >= CH_UPPER_A) && (byte_i <= CH_UPPER_F)) ||
                 ((byte_i >= CH_LOWER_A) && (byte_i <= CH_LOWER_F))) begin
      is_hex_o = 1'b1;
      nibble_o = byte_i[3:0] + 4'd9;
    end else begin
      is_hex_o = 1'b0;
      nibble_o = 4'h0;
    end
  end

endmodule

// File: rtl/uart_cat_cmd_decoder.sv
// Cat-control command parser fed from the UART RX FIFO; maintains the cat_status LED mask.
// Optional TX echo of every accepted byte is enabled with `define UART_CAT_CMD_ECHO_EN.
module uart_cat_cmd_decoder
  import uart_cmd_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 103_340_000,
  parameter int unsigned TIMEOUT_MS = 100,
  parameter logic [7:0]  RESET_MASK = 8'hFF
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [7:0] rx_data_i,
  input  logic       rx_valid_i,
  output logic       rx_ready_o,
  output logic [7:0] cat_status_o,
  output logic       cmd_strobe_o,
  output logic [7:0] err_count_o,
`ifdef UART_CAT_CMD_ECHO_EN
  output logic [7:0] tx_data_o,
  output logic       tx_valid_o,
  input  logic       tx_ready_i,
`endif
  output logic       busy_o
);

  localparam int unsigned TIMEOUT_CYC = CLK_FREQ / 1000 * TIMEOUT_MS;
  localparam int          TW          = $clog2(TIMEOUT_CYC + 1);

  state_e          state_q, state_d;
  logic [7:0]      status_q, status_d;
  logic [7:0]      err_q, err_d;
  logic            strobe_q, strobe_d;
  logic            busy_q, busy_d;
  logic [3:0]      hi_q, hi_d;
  logic [3:0]      lo_q, lo_d;
  logic [TW-1:0]   cnt_q, cnt_d;

  logic            rx_ready_s;
  logic            accept_s;
  logic            is_hex_s;
  logic [3:0]      nibble_s;
  logic [2:0]      up_idx_s;
  logic [2:0]      lo_idx_s;

  hex_nibble_decode u_hex (
    .byte_i   (rx_data_i),
    .is_hex_o (is_hex_s),
    .nibble_o (nibble_s)
  );

`ifdef UART_CAT_CMD_ECHO_EN
  logic [7:0] tx_data_q;
  logic       tx_valid_q;

  // One-entry skid: a new byte may enter only if the slot is empty or drains this same cycle
  assign rx_ready_s = (state_q != ST_APPLY) && (!tx_valid_q || tx_ready_i);

  // Echo register load/drain
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else if (accept_s) begin
      tx_valid_q <= 1'b1;
      tx_data_q  <= rx_data_i;
    end else if (tx_ready_i) begin
      tx_valid_q <= 1'b0;
    end else begin
      tx_valid_q <= tx_valid_q;
    end
  end

  assign tx_data_o  = tx_data_q;
  assign tx_valid_o = tx_valid_q;
`else
  assign rx_ready_s = (state_q != ST_APPLY);
`endif

  assign accept_s = rx_valid_i && rx_ready_s;
  assign up_idx_s = 3'(rx_data_i - CH_UPPER_A);
  assign lo_idx_s = 3'(rx_data_i - CH_LOWER_A);

  // Parser next-state: command decode, hex assembly, inter-byte timeout and error counting
  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    err_d    = err_q;
    strobe_d = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;
    cnt_d    = {TW{1'b0}};
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          if ((rx_data_i >= CH_UPPER_A) && (rx_data_i <= CH_UPPER_H)) begin
            status_d[up_idx_s] = 1'b0;
            strobe_d           = 1'b1;
          end else if ((rx_data_i >= CH_LOWER_A) && (rx_data_i <= CH_LOWER_H)) begin
            status_d[lo_idx_s] = 1'b1;
            strobe_d           = 1'b1;
          end else if (rx_data_i == CH_CLEAR_ALL) begin
            status_d = RESET_MASK;
            strobe_d = 1'b1;
          end else if (rx_data_i == CH_HEX_PREFIX) begin
            state_d = ST_HEX_HI;
          end else if ((rx_data_i == CH_CR) || (rx_data_i == CH_LF) || (rx_data_i == CH_SPACE)) begin
            state_d = ST_IDLE;
          end else begin
            err_d = sat_inc8(err_q);
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HEX_HI, ST_HEX_LO: begin
        if (accept_s) begin
          if (is_hex_s && (state_q == ST_HEX_HI)) begin
            hi_d    = nibble_s;
            state_d = ST_HEX_LO;
          end else if (is_hex_s) begin
            lo_d    = nibble_s;
            state_d = ST_APPLY;
          end else begin
            err_d   = sat_inc8(err_q);
            state_d = ST_IDLE;
          end
        end else if (cnt_q == TW'(TIMEOUT_CYC - 1)) begin
          err_d   = sat_inc8(err_q);
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      ST_APPLY: begin
        status_d = {hi_q, lo_q};
        strobe_d = 1'b1;
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_HEX_HI) || (state_d == ST_HEX_LO);
  end

  // State and output registers; reset discards any partial command
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= ST_IDLE;
      status_q <= RESET_MASK;
      err_q    <= 8'h00;
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
      hi_q     <= 4'h0;
      lo_q     <= 4'h0;
      cnt_q    <= {TW{1'b0}};
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      err_q    <= err_d;
      strobe_q <= strobe_d;
      busy_q   <= busy_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      cnt_q    <= cnt_d;
    end
  end

  assign rx_ready_o   = rx_ready_s;
  assign cat_status_o = status_q;
  assign cmd_strobe_o = strobe_q;
  assign err_count_o  = err_q;
  assign busy_o       = busy_q;

endmodule
